// File: rtl/range_sum_sched_pkg.sv
// Shared widths, FSM state encoding and query record for the range-sum scheduler.
package range_sum_sched_pkg;

  localparam int DATA_W     = 4;
  localparam int NUM_OPS    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = $clog2(NUM_OPS);
  localparam int SUM_W      = DATA_W + IDX_W + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // end_a / end_b are the two range ends (M, m) in whatever order the host gave them
  typedef struct packed {
    logic [IDX_W-1:0] end_a;
    logic [IDX_W-1:0] end_b;
  } query_t;

  function automatic logic [IDX_W-1:0] idx_min(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [IDX_W-1:0] idx_max(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/range_sum_sched_query_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags derived from the count register.
module range_sum_sched_query_fifo #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // pointer, count and storage update; flush discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= WIDTH'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/range_sum_sched.sv
// Operand bank plus queued range-sum queries; one query issued per cycle into a registered result slot.
module range_sum_sched
  import range_sum_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [IDX_W-1:0]  q_M,
  input  logic [IDX_W-1:0]  q_m,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [SUM_W-1:0]  r_sum,
  output logic [IDX_W-1:0]  r_lo,
  output logic [IDX_W-1:0]  r_hi,
  output logic [IDX_W-1:0]  q_count
);

  logic [DATA_W-1:0] bank_r [NUM_OPS];
  query_t            in_query_s;
  query_t            head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [IDX_W-1:0]  lo_s;
  logic [IDX_W-1:0]  hi_s;
  logic [SUM_W-1:0]  sum_s;
  logic              r_valid_r;
  logic [SUM_W-1:0]  r_sum_r;
  logic [IDX_W-1:0]  r_lo_r;
  logic [IDX_W-1:0]  r_hi_r;
  state_e            state_r;
  state_e            state_next_s;

  assign in_query_s = '{end_a: q_M, end_b: q_m};
  // q_ready comes only from the FIFO count register, never from r_ready
  assign q_ready    = ~full_s;
  assign push_s     = q_valid & ~full_s;
  assign pop_s      = ~empty_s & (~r_valid_r | r_ready);
  assign q_count    = IDX_W'(fifo_count_s);
  assign r_valid    = r_valid_r;
  assign r_sum      = r_sum_r;
  assign r_lo       = r_lo_r;
  assign r_hi       = r_hi_r;

  range_sum_sched_query_fifo #(
    .WIDTH ($bits(query_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_query_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_query_s),
    .rd_data (head_s),
    .count   (fifo_count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // bank update; flush leaves the bank untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) bank_r[i] <= DATA_W'(0);
    end else if (wr_en) begin
      bank_r[wr_addr] <= wr_data;
    end
  end

  // masked adder over the pre-write bank so a same-cycle write is not seen by the issuing query
  always_comb begin
    lo_s  = idx_min(head_s.end_a, head_s.end_b);
    hi_s  = idx_max(head_s.end_a, head_s.end_b);
    sum_s = SUM_W'(0);
    for (int i = 0; i < NUM_OPS; i++) begin
      if ((IDX_W'(i) >= lo_s) && (IDX_W'(i) <= hi_s)) begin
        sum_s = sum_s + SUM_W'(bank_r[i]);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  // result slot: load on issue, clear on consume, hold while back-pressured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_r <= 1'b0;
      r_sum_r   <= SUM_W'(0);
      r_lo_r    <= IDX_W'(0);
      r_hi_r    <= IDX_W'(0);
    end else if (flush) begin
      r_valid_r <= 1'b0;
      r_sum_r   <= SUM_W'(0);
      r_lo_r    <= IDX_W'(0);
      r_hi_r    <= IDX_W'(0);
    end else if (pop_s) begin
      r_valid_r <= 1'b1;
      r_sum_r   <= sum_s;
      r_lo_r    <= lo_s;
      r_hi_r    <= hi_s;
    end else if (r_valid_r && r_ready) begin
      r_valid_r <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state: IDLE only once both the FIFO and the slot are empty
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (push_s) state_next_s = ST_RUN;
          else        state_next_s = ST_IDLE;
        end
        ST_RUN: begin
          if (r_valid_r && !r_ready)
            state_next_s = ST_STALL;
          else if (empty_s && !push_s && (!r_valid_r || r_ready))
            state_next_s = ST_IDLE;
          else
            state_next_s = ST_RUN;
        end
        ST_STALL: begin
          if (r_ready) state_next_s = ST_RUN;
          else         state_next_s = ST_STALL;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

endmodule
